// File: rtl/regfile_dbg_pkg.sv
// Shared register-file geometry and snapshot reader state type.
// Imported by the core, the register file and the debug reader.
package regfile_dbg_pkg;

  localparam int RF_NUM_REGS = 8;
  localparam int RF_ADDR_W   = 3;
  localparam int RF_DATA_W   = 16;

  typedef enum logic [2:0] {
    IDLE,
    FREEZE,
    READ,
    SEND,
    DONE
  } snap_state_t;

endpackage

// File: rtl/regfile_snapshot_reader.sv
// Freezes register writes, then streams every register word out
// on a valid/ready port tagged with its index and a last flag.
module regfile_snapshot_reader
  import regfile_dbg_pkg::*;
#(
  parameter int NUM_REGS = RF_NUM_REGS,
  parameter int ADDR_W   = RF_ADDR_W,
  parameter int DATA_W   = RF_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              freeze,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [ADDR_W-1:0] out_index,
  output logic              out_last,
  output logic              busy,
  output logic              done
);

  snap_state_t       state;
  logic [ADDR_W-1:0] idx;
  logic              is_last;

  assign is_last = (idx == ADDR_W'(NUM_REGS - 1));
  assign rd_addr = idx;
  assign busy    = (state != IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      idx       <= '0;
      freeze    <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_index <= '0;
      out_last  <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            state  <= FREEZE;
            freeze <= 1'b1;
            idx    <= '0;
          end
        end
        // Lets a RegWrite issued alongside start land first.
        FREEZE: state <= READ;
        READ: begin
          out_data  <= rd_data;
          out_index <= idx;
          out_last  <= is_last;
          out_valid <= 1'b1;
          state     <= SEND;
        end
        SEND: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if (is_last) begin
              state  <= DONE;
              freeze <= 1'b0;
              done   <= 1'b1;
            end else begin
              idx   <= idx + 1'b1;
              state <= READ;
            end
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_snapshot_reader.sv
// Directed bench for the register snapshot reader with a small
// register-file model whose writes are gated by freeze.
module tb_regfile_snapshot_reader;
  logic        clk = 0;
  logic        rst;
  logic        start;
  logic        freeze;
  logic [2:0]  rd_addr;
  logic [15:0] rd_data;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic [2:0]  out_index;
  logic        out_last;
  logic        busy;
  logic        done;

  logic [15:0] rf [8];
  logic        preload;
  logic        wr_req;
  logic [2:0]  wr_addr;
  logic [15:0] wr_data;

  logic [15:0] bd [16];
  logic [2:0]  bi [16];
  logic        bl [16];

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  regfile_snapshot_reader dut (
    .clk(clk), .rst(rst), .start(start), .freeze(freeze),
    .rd_addr(rd_addr), .rd_data(rd_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data),
    .out_index(out_index), .out_last(out_last), .busy(busy),
    .done(done)
  );

  assign rd_data = rf[rd_addr];

  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 8; i++) rf[i] <= 16'h1000 + 16'(i);
    end else if (wr_req && !freeze) begin
      rf[wr_addr] <= wr_data;
    end
  end

  task automatic do_preload();
    preload = 1;
    @(negedge clk);
    preload = 0;
  endtask

  task automatic pulse_start();
    start = 1;
    @(negedge clk);
    start = 0;
  endtask

  // Runs at negedges until a few cycles past done; records beats.
  task automatic stream(input int mode, input bit restart,
                        output int nb, output int nd, output int nf,
                        output int se, output bit to);
    int cyc, post;
    logic [15:0] pd;
    logic [2:0] pi;
    logic pl;
    bit stalled, kicked;
    nb = 0; nd = 0; nf = 0; se = 0; to = 0;
    cyc = 0; post = -1; stalled = 0; kicked = 0;
    while (post != 0) begin
      if (stalled && (out_valid !== 1'b1 || out_data !== pd ||
          out_index !== pi || out_last !== pl)) se++;
      if (freeze) nf++;
      if (done) begin
        nd++;
        wr_req = 0;
        if (post < 0) post = 5;
      end
      start = 0;
      if (restart && nb == 4 && !kicked) begin
        start = 1;
        kicked = 1;
      end
      case (mode)
        1: out_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
        default: out_ready = 1;
      endcase
      stalled = out_valid && !out_ready;
      pd = out_data; pi = out_index; pl = out_last;
      if (out_valid && out_ready && nb < 16) begin
        bd[nb] = out_data; bi[nb] = out_index; bl[nb] = out_last;
        nb++;
      end
      cyc++;
      if (cyc > 400) begin
        to = 1;
        break;
      end
      if (post > 0) post--;
      @(negedge clk);
    end
    start = 0;
  endtask

  task automatic test_reset();
    tests++;
    if (out_valid !== 0 || freeze !== 0 || busy !== 0 || done !== 0) begin
      fails++;
      $display("FAIL reset_ctl got v%b f%b b%b d%b want 0000",
               out_valid, freeze, busy, done);
    end
    tests++;
    if (out_data !== 0 || out_index !== 0 || out_last !== 0 ||
        rd_addr !== 0) begin
      fails++;
      $display("FAIL reset_data got %h/%0d/%b/%0d want 0",
               out_data, out_index, out_last, rd_addr);
    end
  endtask

  task automatic test_basic();
    int nb, nd, nf, se;
    bit to;
    do_preload();
    pulse_start();
    stream(0, 0, nb, nd, nf, se, to);
    tests++;
    if (to || nb !== 8 || nd !== 1) begin
      fails++;
      $display("FAIL basic_count got beats=%0d done=%0d to=%0d want 8 1 0",
               nb, nd, to);
    end
    for (int i = 0; i < 8; i++) begin
      tests++;
      if (bd[i] !== 16'h1000 + 16'(i) || bi[i] !== 3'(i) ||
          bl[i] !== (i == 7)) begin
        fails++;
        $display("FAIL basic_beat%0d got %h/%0d/%b want %h/%0d/%b",
                 i, bd[i], bi[i], bl[i], 16'h1000 + 16'(i), i, i == 7);
      end
    end
    tests++;
    if (nf !== 17) begin
      fails++;
      $display("FAIL basic_freeze_cycles got %0d want 17", nf);
    end
  endtask

  task automatic test_backpressure();
    int nb, nd, nf, se;
    bit to;
    do_preload();
    pulse_start();
    stream(1, 0, nb, nd, nf, se, to);
    tests++;
    if (to || nb !== 8 || nd !== 1 || se !== 0) begin
      fails++;
      $display("FAIL bp_count got beats=%0d done=%0d unstable=%0d want 8 1 0",
               nb, nd, se);
    end
    for (int i = 0; i < 8; i++) begin
      tests++;
      if (bd[i] !== 16'h1000 + 16'(i) || bi[i] !== 3'(i)) begin
        fails++;
        $display("FAIL bp_beat%0d got %h/%0d want %h/%0d",
                 i, bd[i], bi[i], 16'h1000 + 16'(i), i);
      end
    end
  endtask

  task automatic test_freeze_write();
    int nb, nd, nf, se;
    bit to;
    do_preload();
    pulse_start();
    wr_addr = 3; wr_data = 16'hBEEF; wr_req = 1;
    stream(0, 0, nb, nd, nf, se, to);
    wr_req = 0;
    tests++;
    if (to || nb !== 8 || bd[3] !== 16'h1003) begin
      fails++;
      $display("FAIL frz_stream got beats=%0d r3=%h want 8 1003", nb, bd[3]);
    end
    tests++;
    if (rf[3] !== 16'h1003) begin
      fails++;
      $display("FAIL frz_after got %h want 1003", rf[3]);
    end
  endtask

  task automatic test_restart();
    int nb, nd, nf, se;
    bit to;
    do_preload();
    pulse_start();
    stream(0, 1, nb, nd, nf, se, to);
    tests++;
    if (to || nb !== 8 || nd !== 1) begin
      fails++;
      $display("FAIL restart_count got beats=%0d done=%0d want 8 1", nb, nd);
    end
    for (int i = 0; i < 8; i++) begin
      tests++;
      if (bd[i] !== 16'h1000 + 16'(i) || bi[i] !== 3'(i)) begin
        fails++;
        $display("FAIL restart_beat%0d got %h/%0d want %h/%0d",
                 i, bd[i], bi[i], 16'h1000 + 16'(i), i);
      end
    end
  endtask

  task automatic test_async_reset();
    int nb, nd, nf, se, n;
    bit to;
    do_preload();
    pulse_start();
    out_ready = 1;
    n = 0;
    while (!(out_valid && out_index == 5) && n < 40) begin
      @(negedge clk);
      n++;
    end
    tests++;
    if (n >= 40) begin
      fails++;
      $display("FAIL rst_reach_idx5 got timeout want idx5 beat");
    end
    out_ready = 0;
    @(posedge clk);
    #2 rst = 0;
    #1;
    tests++;
    if (out_valid !== 0 || freeze !== 0 || busy !== 0 || done !== 0 ||
        rd_addr !== 0) begin
      fails++;
      $display("FAIL rst_mid got v%b f%b b%b d%b a%0d want 0 0 0 0 0",
               out_valid, freeze, busy, done, rd_addr);
    end
    @(negedge clk);
    rst = 1;
    @(negedge clk);
    pulse_start();
    stream(0, 0, nb, nd, nf, se, to);
    tests++;
    if (to || nb !== 8 || bi[0] !== 0 || bd[0] !== 16'h1000 ||
        bi[7] !== 7) begin
      fails++;
      $display("FAIL rst_fresh got beats=%0d first=%0d/%h want 8 0/1000",
               nb, bi[0], bd[0]);
    end
  endtask

  task automatic test_stall();
    int nb, nd, nf, se, n, bad;
    bit to;
    do_preload();
    out_ready = 0;
    pulse_start();
    n = 0;
    while (!out_valid && n < 10) begin
      @(negedge clk);
      n++;
    end
    bad = 0;
    for (int c = 0; c < 50; c++) begin
      if (out_valid !== 1 || freeze !== 1 || busy !== 1 ||
          out_data !== 16'h1000 || out_index !== 0) bad++;
      @(negedge clk);
    end
    tests++;
    if (bad !== 0 || n >= 10) begin
      fails++;
      $display("FAIL stall_hold got %0d bad cycles want 0", bad);
    end
    stream(0, 0, nb, nd, nf, se, to);
    tests++;
    if (to || nb !== 8 || nd !== 1 || bd[0] !== 16'h1000 ||
        bd[7] !== 16'h1007) begin
      fails++;
      $display("FAIL stall_release got beats=%0d done=%0d want 8 1",
               nb, nd);
    end
  endtask

  initial begin
    rst = 0; start = 0; out_ready = 0;
    preload = 0; wr_req = 0; wr_addr = 0; wr_data = 0;
    @(negedge clk);
    @(negedge clk);
    test_reset();
    rst = 1;
    @(negedge clk);
    test_basic();
    test_backpressure();
    test_freeze_write();
    test_restart();
    test_async_reset();
    test_stall();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
